// File: rtl/instr_fetch_queue.sv
// i281 fetch front-end: drives the PC load port, issues ROM reads and buffers returns in a DEPTH-entry queue.
// Optional build macro IFQ_STATS_EN adds saturating Fetch_Count / Flush_Count outputs.
module instr_fetch_queue #(
    parameter int N     = 6,
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] PC_Output,
    output logic [N-1:0] PC_Input,
    output logic         Control,
    output logic [N-1:0] IMem_Addr,
    output logic         IMem_En,
    input  logic [W-1:0] IMem_Data,
    input  logic         Redirect_Valid,
    input  logic [N-1:0] Redirect_Target,
    output logic         Instr_Valid,
    input  logic         Instr_Ready,
    output logic [W-1:0] Instr_Data,
    output logic [N-1:0] Instr_PC
`ifdef IFQ_STATS_EN
    ,
    output logic [7:0]   Fetch_Count,
    output logic [7:0]   Flush_Count
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;

    logic [W-1:0]  data_reg [DEPTH];
    logic [N-1:0]  pc_reg   [DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          inflight_reg;
    logic [N-1:0]  inflight_pc_reg;

    logic          deq;
    logic          enq;
    logic          issue;
    logic [OW-1:0] occupancy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1))
            return '0;
        else
            return p + PW'(1);
    endfunction

    assign Instr_Valid = (count_reg != '0) & ~Redirect_Valid;
    assign Instr_Data  = data_reg[rd_ptr_reg];
    assign Instr_PC    = pc_reg[rd_ptr_reg];
    assign deq         = Instr_Valid & Instr_Ready;
    assign enq         = inflight_reg & ~Redirect_Valid;

    // Entries already held or on their way, less the one leaving this cycle.
    assign occupancy = OW'(count_reg) + OW'(inflight_reg) - OW'(deq);
    assign issue     = ~Reset & ~Redirect_Valid & (occupancy < OW'(DEPTH));

    assign IMem_Addr = PC_Output;
    assign IMem_En   = issue;

    always_comb begin
        Control  = 1'b0;
        PC_Input = PC_Output;
        if (!Reset) begin
            if (Redirect_Valid) begin
                Control  = 1'b1;
                PC_Input = Redirect_Target;
            end else if (issue) begin
                Control  = 1'b1;
                PC_Input = PC_Output + N'(1);
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
        end else if (Redirect_Valid) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            inflight_reg <= 1'b0;
        end else begin
            if (enq)
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (deq)
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({enq, deq})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            inflight_reg <= issue;
            if (issue)
                inflight_pc_reg <= PC_Output;
        end
    end

    // Payload storage needs no reset; validity is tracked by count_reg.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge Clock) begin
            if (enq && (wr_ptr_reg == PW'(gi))) begin
                data_reg[gi] <= IMem_Data;
                pc_reg[gi]   <= inflight_pc_reg;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset)
            assert (!(inflight_reg && (count_reg == CW'(DEPTH))));
    end

`ifdef IFQ_STATS_EN
    logic [7:0] fetch_count_reg;
    logic [7:0] flush_count_reg;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            fetch_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            if (IMem_En && (fetch_count_reg != 8'hFF))
                fetch_count_reg <= fetch_count_reg + 8'd1;
            if (Redirect_Valid && (flush_count_reg != 8'hFF))
                flush_count_reg <= flush_count_reg + 8'd1;
        end
    end

    assign Fetch_Count = fetch_count_reg;
    assign Flush_Count = flush_count_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: models the external PC register and a 1-cycle ROM, runs directed
// scenarios plus a randomized run checked against an in-order program-stream model.
module tb_instr_fetch_queue;
    localparam int N     = 6;
    localparam int W     = 16;
    localparam int DEPTH = 2;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic [N-1:0] pc_q;
    logic [N-1:0] PC_Input;
    logic         Control;
    logic [N-1:0] IMem_Addr;
    logic         IMem_En;
    logic [W-1:0] rom_q;
    logic         Redirect_Valid = 1'b0;
    logic [N-1:0] Redirect_Target = '0;
    logic         Instr_Valid;
    logic         Instr_Ready = 1'b1;
    logic [W-1:0] Instr_Data;
    logic [N-1:0] Instr_PC;
`ifdef IFQ_STATS_EN
    logic [7:0]   Fetch_Count;
    logic [7:0]   Flush_Count;
`endif

    logic [W-1:0] rom_mem [64];
    int tests_run    = 0;
    int tests_failed = 0;

    always #5 Clock = ~Clock;

    // External program counter and synchronous instruction ROM.
    always @(posedge Clock or posedge Reset) begin
        if (Reset)
            pc_q <= '0;
        else if (Control)
            pc_q <= PC_Input;
    end

    always @(posedge Clock) begin
        if (IMem_En)
            rom_q <= rom_mem[IMem_Addr];
    end

    instr_fetch_queue #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .PC_Output       (pc_q),
        .PC_Input        (PC_Input),
        .Control         (Control),
        .IMem_Addr       (IMem_Addr),
        .IMem_En         (IMem_En),
        .IMem_Data       (rom_q),
        .Redirect_Valid  (Redirect_Valid),
        .Redirect_Target (Redirect_Target),
        .Instr_Valid     (Instr_Valid),
        .Instr_Ready     (Instr_Ready),
        .Instr_Data      (Instr_Data),
        .Instr_PC        (Instr_PC)
`ifdef IFQ_STATS_EN
        ,
        .Fetch_Count     (Fetch_Count),
        .Flush_Count     (Flush_Count)
`endif
    );

    task automatic test_reset();
        Instr_Ready = 1'b1;
        Redirect_Valid = 1'b0;
        Reset = 1'b1;
        @(negedge Clock); #1;
        tests_run++;
        if ({Instr_Valid, IMem_En, Control} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_hold: valid/en/ctl=%b expected 000", {Instr_Valid, IMem_En, Control});
        end
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        tests_run++;
        if ({IMem_En, Control, IMem_Addr, PC_Input} !== {1'b1, 1'b1, 6'd0, 6'd1}) begin
            tests_failed++;
            $display("FAIL first_issue: en=%b ctl=%b addr=%0d pcin=%0d expected 1 1 0 1",
                     IMem_En, Control, IMem_Addr, PC_Input);
        end
        @(negedge Clock); #1;
        tests_run++;
        if (Instr_Valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL cycle1_valid: got %b expected 0", Instr_Valid);
        end
        for (int k = 0; k < 9; k++) begin
            if (k > 0) begin
                @(negedge Clock); #1;
            end else begin
                @(negedge Clock); #1;
            end
            tests_run++;
            if ({Instr_Valid, Instr_PC, Instr_Data} !== {1'b1, N'(k), 16'hA000 + 16'(k)}) begin
                tests_failed++;
                $display("FAIL stream_%0d: valid=%b pc=%0d data=%h expected 1 %0d %h",
                         k, Instr_Valid, Instr_PC, Instr_Data, k, 16'hA000 + 16'(k));
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_backpressure();
        int fetches = 0;
        @(negedge Clock);
        Instr_Ready = 1'b0;
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (IMem_En) fetches++;
            @(negedge Clock); #1;
        end
        tests_run++;
        if (fetches != DEPTH) begin
            tests_failed++;
            $display("FAIL bp_fetches: got %0d expected %0d", fetches, DEPTH);
        end
        tests_run++;
        if ({Control, pc_q} !== {1'b0, 6'd2}) begin
            tests_failed++;
            $display("FAIL bp_hold: ctl=%b pc=%0d expected 0 2", Control, pc_q);
        end
        Instr_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if ({Instr_Valid, Instr_PC, Instr_Data} !== {1'b1, N'(i), 16'hA000 + 16'(i)}) begin
                tests_failed++;
                $display("FAIL bp_drain_%0d: valid=%b pc=%0d data=%h expected 1 %0d", i,
                         Instr_Valid, Instr_PC, Instr_Data, i);
            end
            @(negedge Clock);
        end
        $display("[TB] test_backpressure done");
    endtask

    task automatic test_redirect();
        bit found = 0;
        @(negedge Clock);
        Instr_Ready = 1'b1;
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge Clock); #1;
            if (Instr_Valid && Instr_PC == 6'd5) found = 1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL redir_setup: PC 5 not presented within 20 cycles");
        end
        Redirect_Valid = 1'b1;
        Redirect_Target = 6'd40;
        #1;
        tests_run++;
        if ({Instr_Valid, IMem_En, Control, PC_Input} !== {1'b0, 1'b0, 1'b1, 6'd40}) begin
            tests_failed++;
            $display("FAIL redir_cycle: valid=%b en=%b ctl=%b pcin=%0d expected 0 0 1 40",
                     Instr_Valid, IMem_En, Control, PC_Input);
        end
        @(negedge Clock);
        Redirect_Valid = 1'b0;
        #1;
        tests_run++;
        if ({IMem_En, IMem_Addr, Instr_Valid} !== {1'b1, 6'd40, 1'b0}) begin
            tests_failed++;
            $display("FAIL redir_r1: en=%b addr=%0d valid=%b expected 1 40 0", IMem_En, IMem_Addr, Instr_Valid);
        end
        @(negedge Clock); #1;
        tests_run++;
        if (Instr_Valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_r2: valid=%b pc=%0d expected no instruction", Instr_Valid, Instr_PC);
        end
        @(negedge Clock); #1;
        tests_run++;
        if ({Instr_Valid, Instr_PC, Instr_Data} !== {1'b1, 6'd40, 16'hA028}) begin
            tests_failed++;
            $display("FAIL redir_r3: valid=%b pc=%0d data=%h expected 1 40 a028", Instr_Valid, Instr_PC, Instr_Data);
        end
        @(negedge Clock); #1;
        tests_run++;
        if ({Instr_Valid, Instr_PC} !== {1'b1, 6'd41}) begin
            tests_failed++;
            $display("FAIL redir_r4: valid=%b pc=%0d expected 1 41", Instr_Valid, Instr_PC);
        end
        $display("[TB] test_redirect done");
    endtask

    task automatic test_back_to_back();
        @(negedge Clock);
        Redirect_Valid = 1'b1;
        Redirect_Target = 6'd10;
        @(negedge Clock);
        Redirect_Target = 6'd20;
        #1;
        tests_run++;
        if ({Control, PC_Input, Instr_Valid} !== {1'b1, 6'd20, 1'b0}) begin
            tests_failed++;
            $display("FAIL b2b_second: ctl=%b pcin=%0d valid=%b expected 1 20 0", Control, PC_Input, Instr_Valid);
        end
        @(negedge Clock);
        Redirect_Valid = 1'b0;
        #1;
        tests_run++;
        if ({IMem_En, IMem_Addr} !== {1'b1, 6'd20}) begin
            tests_failed++;
            $display("FAIL b2b_fetch: en=%b addr=%0d expected 1 20", IMem_En, IMem_Addr);
        end
        @(negedge Clock); #1;
        tests_run++;
        if (Instr_Valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_gap: valid=%b pc=%0d expected 0", Instr_Valid, Instr_PC);
        end
        @(negedge Clock); #1;
        tests_run++;
        if ({Instr_Valid, Instr_PC} !== {1'b1, 6'd20}) begin
            tests_failed++;
            $display("FAIL b2b_head: valid=%b pc=%0d expected 1 20", Instr_Valid, Instr_PC);
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_wrap();
        logic [N-1:0] e = 6'd62;
        @(negedge Clock);
        Redirect_Valid = 1'b1;
        Redirect_Target = 6'd62;
        @(negedge Clock);
        Redirect_Valid = 1'b0;
        @(negedge Clock); #1;
        tests_run++;
        if ({IMem_En, Control, IMem_Addr, PC_Input} !== {1'b1, 1'b1, 6'd63, 6'd0}) begin
            tests_failed++;
            $display("FAIL wrap_pcin: en=%b ctl=%b addr=%0d pcin=%0d expected 1 1 63 0",
                     IMem_En, Control, IMem_Addr, PC_Input);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock); #1;
            tests_run++;
            if ({Instr_Valid, Instr_PC, Instr_Data} !== {1'b1, e, 16'hA000 + 16'(e)}) begin
                tests_failed++;
                $display("FAIL wrap_seq_%0d: valid=%b pc=%0d data=%h expected 1 %0d", i,
                         Instr_Valid, Instr_PC, Instr_Data, e);
            end
            e = e + N'(1);
        end
        $display("[TB] test_wrap done");
    endtask

    task automatic test_async_reset();
        @(negedge Clock);
        Instr_Ready = 1'b0;
        repeat (4) @(negedge Clock);
        #1;
        tests_run++;
        if (Instr_Valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL arst_pre: valid=%b expected 1", Instr_Valid);
        end
        #2;
        Reset = 1'b1;
        #1;
        tests_run++;
        if ({Instr_Valid, IMem_En, Control} !== 3'b000) begin
            tests_failed++;
            $display("FAIL arst_drop: valid/en/ctl=%b expected 000", {Instr_Valid, IMem_En, Control});
        end
        @(negedge Clock);
        Reset = 1'b0;
        Instr_Ready = 1'b1;
        #1;
        tests_run++;
        if ({IMem_En, IMem_Addr, Instr_Valid} !== {1'b1, 6'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL arst_restart: en=%b addr=%0d valid=%b expected 1 0 0", IMem_En, IMem_Addr, Instr_Valid);
        end
        @(negedge Clock);
        @(negedge Clock); #1;
        tests_run++;
        if ({Instr_Valid, Instr_PC} !== {1'b1, 6'd0}) begin
            tests_failed++;
            $display("FAIL arst_first: valid=%b pc=%0d expected 1 0", Instr_Valid, Instr_PC);
        end
        $display("[TB] test_async_reset done");
    endtask

    // Model: the decode side must see the program in order from the last restart point;
    // three cycles after a restart the head is always valid; never more than DEPTH fetched ahead.
    task automatic test_random();
        logic [N-1:0] exp_pc = '0;
        int since_flush = 1;
        int outstanding = 0;
        bit rv;
        logic [N-1:0] tgt;
        for (int i = 0; i < 64; i++) rom_mem[i] = 16'($urandom);
        @(negedge Clock);
        Reset = 1'b1;
        Redirect_Valid = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rv = ($urandom_range(0, 39) == 0);
            tgt = N'($urandom);
            Instr_Ready = ($urandom_range(0, 3) != 0);
            Redirect_Valid = rv;
            Redirect_Target = tgt;
            #1;
            if (rv) begin
                tests_run++;
                if ({Instr_Valid, IMem_En, Control, PC_Input} !== {1'b0, 1'b0, 1'b1, tgt}) begin
                    tests_failed++;
                    $display("FAIL rnd_redirect c%0d: valid=%b en=%b ctl=%b pcin=%0d expected 0 0 1 %0d",
                             c, Instr_Valid, IMem_En, Control, PC_Input, tgt);
                end
                exp_pc = tgt;
                outstanding = 0;
                since_flush = 0;
            end else begin
                if (since_flush >= 3) begin
                    tests_run++;
                    if (Instr_Valid !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL rnd_live c%0d: valid=%b expected 1", c, Instr_Valid);
                    end
                end
                if (Instr_Valid === 1'b1 && Instr_Ready) begin
                    tests_run++;
                    if ({Instr_PC, Instr_Data} !== {exp_pc, rom_mem[exp_pc]}) begin
                        tests_failed++;
                        $display("FAIL rnd_deliver c%0d: pc=%0d data=%h expected %0d %h",
                                 c, Instr_PC, Instr_Data, exp_pc, rom_mem[exp_pc]);
                    end
                    exp_pc = exp_pc + N'(1);
                    outstanding--;
                end
                if (IMem_En === 1'b1) outstanding++;
                tests_run++;
                if (outstanding > DEPTH) begin
                    tests_failed++;
                    $display("FAIL rnd_ahead c%0d: outstanding=%0d expected <= %0d", c, outstanding, DEPTH);
                end
            end
            if (since_flush < 100) since_flush++;
            @(negedge Clock);
        end
        Redirect_Valid = 1'b0;
        Instr_Ready = 1'b1;
        $display("[TB] test_random done");
    endtask

`ifdef IFQ_STATS_EN
    task automatic test_stats();
        int fetches = 0;
        int cycles = 0;
        @(negedge Clock);
        Instr_Ready = 1'b1;
        Redirect_Valid = 1'b0;
        Reset = 1'b1;
        #1;
        tests_run++;
        if ({Fetch_Count, Flush_Count} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL stats_reset: fetch=%0d flush=%0d expected 0 0", Fetch_Count, Flush_Count);
        end
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        while (fetches < 300 && cycles < 400) begin
            if (IMem_En) fetches++;
            @(negedge Clock); #1;
            cycles++;
            if (fetches == 100 && IMem_En) begin
                tests_run++;
                if (Fetch_Count !== 8'd100) begin
                    tests_failed++;
                    $display("FAIL stats_fetch100: got %0d expected 100", Fetch_Count);
                end
            end
        end
        tests_run++;
        if (fetches < 300) begin
            tests_failed++;
            $display("FAIL stats_budget: only %0d fetches in %0d cycles", fetches, cycles);
        end
        @(negedge Clock);
        Redirect_Valid = 1'b1;
        @(negedge Clock);
        Redirect_Valid = 1'b0;
        @(negedge Clock);
        Redirect_Valid = 1'b1;
        @(negedge Clock);
        Redirect_Valid = 1'b0;
        #1;
        tests_run++;
        if ({Fetch_Count, Flush_Count} !== {8'd255, 8'd2}) begin
            tests_failed++;
            $display("FAIL stats_final: fetch=%0d flush=%0d expected 255 2", Fetch_Count, Flush_Count);
        end
        $display("[TB] test_stats done");
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) rom_mem[i] = 16'hA000 + 16'(i);
        test_reset();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_async_reset();
`ifdef IFQ_STATS_EN
        test_stats();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Fetch front-end for the i281 CPU. It reads the program counter value, addresses instruction memory, and drives the program counter's load port (`PC_Input`, `Control`) to advance or redirect fetch. Returned instructions are buffered in a small FIFO and handed to decode with a valid/ready handshake. It sits between the program counter, the instruction ROM, and the decode stage.

## Interface
- `N`, 6, PC / instruction-address width
- `W`, 16, instruction width
- `DEPTH`, 2, instruction queue entries (≥2)

- `Clock`  in  1  single clock; all state updates on rising edge
- `Reset`  in  1  asynchronous, active-high; clears all state immediately
- `PC_Output`  in  N  current program counter value
- `PC_Input`  out  N  next PC value presented to the program counter
- `Control`  out  1  PC load enable; the PC takes `PC_Input` on the next edge when 1
- `IMem_Addr`  out  N  instruction memory address, always equal to `PC_Output`
- `IMem_En`  out  1  fetch issued this cycle
- `IMem_Data`  in  W  read data, valid one cycle after `IMem_En`
- `Redirect_Valid`  in  1  branch/jump redirect request
- `Redirect_Target`  in  N  redirect destination
- `Instr_Valid`  out  1  queue head valid
- `Instr_Ready`  in  1  decode accepts head
- `Instr_Data`  out  W  head instruction
- `Instr_PC`  out  N  address the head instruction was fetched from

## Operation
- State:
  - circular queue of `DEPTH` entries {data, pc}
  - read/write pointers and `count`
  - `inflight` flag plus `inflight_pc`, for one outstanding ROM read
- `deq` = `Instr_Valid & Instr_Ready & ~Redirect_Valid`.
- `issue` = `~Redirect_Valid & (count + inflight - deq < DEPTH)`. This is combinational and depends on `Instr_Ready`.
- On `issue`:
  - `IMem_En`=1, `Control`=1, `PC_Input` = `PC_Output`+1 modulo 2^N (so 2^N-1 wraps to 0).
  - At the edge: `inflight`←1, `inflight_pc`←`PC_Output`.
- With no issue and no redirect: `Control`=0, and `PC_Input` = `PC_Output` (don't-care, but held for determinism).
- Return: when `inflight`=1, `IMem_Data` and `inflight_pc` are enqueued at the edge. `inflight` clears unless a new issue occurs in the same cycle.
- Redirect has priority over everything:
  - `Control`=1, `PC_Input`=`Redirect_Target`, `IMem_En`=0, `Instr_Valid` forced 0.
  - At the edge: queue emptied (pointers and `count` to 0), `inflight`←0. Any data returning this cycle is discarded.
- Enqueue and dequeue may occur in the same cycle; `count` is unchanged.
- The issue rule guarantees an enqueue never finds the queue full. A full queue with `inflight`=1 is an assertion failure.
- `Instr_Valid` = (`count`≠0) & `~Redirect_Valid`. `Instr_Data`/`Instr_PC` show the head entry; their value is undefined when `count`=0.

## Timing
- Reset (asynchronous, any time):
  - `count`=0, `inflight`=0, pointers 0.
  - `Instr_Valid`=0, `IMem_En`=0, `Control`=0 while `Reset`=1.
  - Reset mid-operation discards queued and in-flight instructions.
- Fetch latency: issue in cycle t → data at ROM in t+1 → `Instr_Valid` in t+2.
- Throughput: one instruction per cycle sustained when decode holds `Instr_Ready`=1.
- After `Reset` falls: the first issue is in cycle 0 at address `PC_Output`=0, and `Instr_PC`=0 is valid in cycle 2.
- Redirect asserted in cycle r:
  - The PC loads the target at the end of r.
  - The target is fetched in r+1 and presented in r+3.
  - Back-to-back redirects: the last one wins.
- Backpressure: with `Instr_Ready`=0, at most `DEPTH` instructions are fetched past the head, then `Control`=0 and the PC holds.

## Configuration
- `IFQ_STATS_EN`:
  - When defined, adds outputs `Fetch_Count` [7:0] and `Flush_Count` [7:0].
  - `Fetch_Count` increments per `IMem_En`; `Flush_Count` increments per `Redirect_Valid` cycle.
  - Both saturate at 255 and are cleared by `Reset`.
  - When undefined, these ports and counters do not exist and behaviour is otherwise identical.

## Test plan
- Reset release, `Instr_Ready`=1, ROM[i]=16'hA000+i:
  - `Instr_Valid` first in cycle 2 with `Instr_PC`=0, `Instr_Data`=16'hA000.
  - Then one instruction per cycle with PCs 1, 2, 3…
- `Instr_Ready`=0 from cycle 0 → exactly 2 fetches (PC 0, 1), then `Control`=0 and the PC holds at 2. Raise Ready → 0, 1, 2 delivered in order with no gaps or duplicates.
- `Redirect_Valid` with `Redirect_Target`=6'd40 while queue holds PCs 5 and 6 and PC 7 is in flight:
  - Next valid instruction is `Instr_PC`=40, three cycles later.
  - PCs 5, 6, 7 are never presented.
- PC=63 fetch → `PC_Input`=0, `Control`=1; the following instruction has `Instr_PC`=0.
- `Reset` pulsed asynchronously mid-stream (between edges) with a non-empty queue → `Instr_Valid` drops immediately; after release, fetch restarts at PC 0.
- With `IFQ_STATS_EN`: 300 fetches and 2 redirects → `Fetch_Count`=255, `Flush_Count`=2.
